// File: rtl/alu_result_fifo.sv
// alu_result_fifo: show-ahead FIFO capturing ALU results, with sticky overflow flag and saturating ovf/drop counters
module alu_result_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_wr_en,
  input  logic signed [DATA_W-1:0]   i_result,
  input  logic                       i_carry,
  input  logic                       i_ovf,
  input  logic                       i_rd_ready,
  output logic                       o_valid,
  output logic signed [DATA_W-1:0]   o_result,
  output logic                       o_carry,
  output logic                       o_ovf,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  input  logic                       i_clr_sticky,
  output logic                       o_sticky_ovf,
  output logic [CNT_W-1:0]           o_ovf_cnt,
  output logic [CNT_W-1:0]           o_drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + 2;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic pop, push, drop, ovf_ev, sticky_nxt;
  logic [CNT_W-1:0] ovf_nxt, drop_nxt;
  assign o_count = count;
  assign o_full = count == (AW+1)'(DEPTH);
  assign o_empty = count == '0;
  assign o_valid = ~o_empty;
  assign pop = o_valid & i_rd_ready;
  assign push = i_wr_en & (~o_full | pop);
  assign drop = i_wr_en & o_full & ~pop;
  assign ovf_ev = i_wr_en & i_ovf;
  // Outputs are forced to zero when empty so stale storage never leaks out
  assign {o_result, o_carry, o_ovf} = o_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr] <= {i_result, i_carry, i_ovf};
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // A clear coinciding with an event leaves the counter at 1, not 0
  always_comb begin
    ovf_nxt = i_clr_sticky ? CNT_W'(ovf_ev) : (ovf_ev && o_ovf_cnt != '1) ? o_ovf_cnt + CNT_W'(1) : o_ovf_cnt;
    drop_nxt = i_clr_sticky ? CNT_W'(drop) : (drop && o_drop_cnt != '1) ? o_drop_cnt + CNT_W'(1) : o_drop_cnt;
    sticky_nxt = ovf_ev | (~i_clr_sticky & o_sticky_ovf);
  end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      o_sticky_ovf <= 1'b0;
      o_ovf_cnt <= '0;
      o_drop_cnt <= '0;
    end else begin
      o_sticky_ovf <= sticky_nxt;
      o_ovf_cnt <= ovf_nxt;
      o_drop_cnt <= drop_nxt;
    end
endmodule
